// File: rtl/hpm_window_detector.sv
// hpm_window_detector
//   Consumes the HPM tracer read-out phase. On EnableDetect the 32 counter
//   values on HPMout are latched, then scanned one counter per cycle. Each
//   counter's delta against the previous window's baseline is saturated to
//   32 bits and compared (strictly greater) against a per-counter threshold.
//   A one-cycle EndDetect pulse returns the verdict and releases the tracer.
//
//   Optional feature macro: HPM_DET_MASK_EN adds a per-counter enable mask
//   written at cfg_idx = 32 (reset all-ones). Without it every counter is
//   evaluated and writes to index 32 are dropped.
//
// Ports
//   clk_h         clock, rising edge
//   rst_h         asynchronous active-low reset
//   EnableDetect  tracer read-out phase active (level)
//   HPMout        live counter snapshot, valid while EnableDetect = 1
//   EndDetect     one-cycle pulse, window evaluated
//   cfg_we        threshold / mask write strobe
//   cfg_idx       0..NUM_CNT-1 threshold, NUM_CNT mask (macro only)
//   cfg_data      write data
//   cfg_busy      high while scanning / finishing; writes ignored then
//   alarm         exceed_cnt >= ALARM_MIN for last completed window
//   exceed_cnt    number of exceeding counters in last completed window
//   exceed_vec    per-counter exceed flags of last completed window
module hpm_window_detector #(
    parameter int NUM_CNT   = 32,
    parameter int CNT_W     = 64,
    parameter int ALARM_MIN = 4
) (
    input  logic                            clk_h,
    input  logic                            rst_h,
    input  logic                            EnableDetect,
    input  logic [NUM_CNT-1:0][CNT_W-1:0]   HPMout,
    output logic                            EndDetect,
    input  logic                            cfg_we,
    input  logic [5:0]                      cfg_idx,
    input  logic [31:0]                     cfg_data,
    output logic                            cfg_busy,
    output logic                            alarm,
    output logic [5:0]                      exceed_cnt,
    output logic [NUM_CNT-1:0]              exceed_vec
);

    localparam int IDX_W = $clog2(NUM_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2,
        WAITLOW = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_CNT-1:0][CNT_W-1:0]   snap_q, snap_d;
    logic [NUM_CNT-1:0][CNT_W-1:0]   base_q, base_d;
    logic                            base_valid_q, base_valid_d;
    logic [NUM_CNT-1:0][31:0]        thr_q, thr_d;
    logic [NUM_CNT-1:0]              acc_vec_q, acc_vec_d;
    logic [5:0]                      acc_cnt_q, acc_cnt_d;
    logic [NUM_CNT-1:0]              exceed_vec_q, exceed_vec_d;
    logic [5:0]                      exceed_cnt_q, exceed_cnt_d;
    logic                            alarm_q, alarm_d;
    logic [NUM_CNT-1:0]              mask_eff;

    logic [CNT_W-1:0]                delta;
    logic [31:0]                     dsat;
    logic                            hit;
    logic                            cfg_open;

    // Deltas that do not fit in 32 bits compare as the largest value, so a
    // huge jump still exceeds any threshold below all-ones.
    function automatic logic [31:0] sat32(input logic [CNT_W-1:0] d);
        if (d[CNT_W-1:32] != '0) begin
            return 32'hFFFF_FFFF;
        end
        return d[31:0];
    endfunction

`ifdef HPM_DET_MASK_EN
    logic [NUM_CNT-1:0] mask_q, mask_d;
    assign mask_eff = mask_q;
`else
    assign mask_eff = '1;
`endif

    // Modulo-2^CNT_W subtraction gives the right delta across counter wrap.
    assign delta    = snap_q[idx_q] - base_q[idx_q];
    assign dsat     = sat32(delta);
    assign hit      = base_valid_q && mask_eff[idx_q] && (dsat > thr_q[idx_q]);
    assign cfg_open = (state_q == IDLE) || (state_q == WAITLOW);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        base_d       = base_q;
        base_valid_d = base_valid_q;
        thr_d        = thr_q;
        acc_vec_d    = acc_vec_q;
        acc_cnt_d    = acc_cnt_q;
        exceed_vec_d = exceed_vec_q;
        exceed_cnt_d = exceed_cnt_q;
        alarm_d      = alarm_q;
`ifdef HPM_DET_MASK_EN
        mask_d       = mask_q;
`endif

        // A write coinciding with the EnableDetect rise lands before the
        // first scan cycle reads the threshold.
        if (cfg_we && cfg_open) begin
            if (cfg_idx < 6'(NUM_CNT)) begin
                thr_d[cfg_idx[IDX_W-1:0]] = cfg_data;
            end
`ifdef HPM_DET_MASK_EN
            else if (cfg_idx == 6'(NUM_CNT)) begin
                mask_d = cfg_data[NUM_CNT-1:0];
            end
`endif
        end

        unique case (state_q)
            IDLE: begin
                if (EnableDetect) begin
                    snap_d    = HPMout;
                    acc_vec_d = '0;
                    acc_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                // Tracer left read-out early: drop the window, keep results.
                if (!EnableDetect) begin
                    state_d = IDLE;
                end else begin
                    if (hit) begin
                        acc_vec_d[idx_q] = 1'b1;
                        acc_cnt_d        = acc_cnt_q + 6'd1;
                    end
                    if (idx_q == IDX_W'(NUM_CNT - 1)) begin
                        exceed_vec_d = acc_vec_d;
                        exceed_cnt_d = acc_cnt_d;
                        alarm_d      = (acc_cnt_d >= 6'(ALARM_MIN));
                        base_d       = snap_q;
                        base_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = WAITLOW;
            end
            WAITLOW: begin
                if (!EnableDetect) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            base_q       <= '0;
            base_valid_q <= 1'b0;
            thr_q        <= '1;
            acc_vec_q    <= '0;
            acc_cnt_q    <= '0;
            exceed_vec_q <= '0;
            exceed_cnt_q <= '0;
            alarm_q      <= 1'b0;
`ifdef HPM_DET_MASK_EN
            mask_q       <= '1;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            base_q       <= base_d;
            base_valid_q <= base_valid_d;
            thr_q        <= thr_d;
            acc_vec_q    <= acc_vec_d;
            acc_cnt_q    <= acc_cnt_d;
            exceed_vec_q <= exceed_vec_d;
            exceed_cnt_q <= exceed_cnt_d;
            alarm_q      <= alarm_d;
`ifdef HPM_DET_MASK_EN
            mask_q       <= mask_d;
`endif
        end
    end

    // Snapshot is pure data, always reloaded before it is read.
    always_ff @(posedge clk_h) begin
        snap_q <= snap_d;
    end

    assign EndDetect  = (state_q == DONE);
    assign cfg_busy   = (state_q == SCAN) || (state_q == DONE);
    assign alarm      = alarm_q;
    assign exceed_cnt = exceed_cnt_q;
    assign exceed_vec = exceed_vec_q;

endmodule
